// File: rtl/mic1_shift_pkg.sv
// mic1_shift_pkg
//   Shared types for the MIC-1 shift sequencer: shifter SET encoding,
//   sequencer state encoding and the datapath width.
package mic1_shift_pkg;

    localparam int DATA_W = 32;

    // Shifter SET encoding; SH_RSVD is never driven to the shifter.
    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_SLL8 = 2'b01,
        SH_SRA1 = 2'b10,
        SH_RSVD = 2'b11
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_t;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// shift_sequencer_shifter
//   Single-step MIC-1 shifter (purely combinational).
// Ports
//   i_alu_out  in   DATA_W  value to shift
//   i_set      in   2       SET code: pass / SLL8 / SRA1 (reserved passes through)
//   o_shift    out  DATA_W  shifted value
module shift_sequencer_shifter
    import mic1_shift_pkg::*;
(
    input  logic [DATA_W-1:0] i_alu_out,
    input  shift_op_t         i_set,
    output logic [DATA_W-1:0] o_shift
);

    logic signed [DATA_W-1:0] w_in_s;

    assign w_in_s = i_alu_out;

    always_comb begin
        o_shift = i_alu_out;
        case (i_set)
            SH_SLL8: o_shift = {i_alu_out[DATA_W-9:0], 8'h00};
            SH_SRA1: o_shift = w_in_s >>> 1;
            default: o_shift = i_alu_out;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle controller around the single-step MIC-1 shifter. A request
//   loads an accumulator which is fed back through the shifter once per
//   cycle until the repeat count runs out (or, with EARLY_EXIT, until further
//   passes can no longer change it). The result is returned over a
//   valid/ready response port.
// Parameters
//   CNT_W       width of the repeat count
//   EARLY_EXIT  1: stop as soon as the accumulator reaches a fixed point
// Ports
//   CLK, RST               clock (rising edge), asynchronous active-high reset
//   REQ_VALID/REQ_READY    request handshake; REQ_READY only in IDLE
//   REQ_OP/REQ_DATA/REQ_CNT shift code, operand, number of passes
//   RSP_VALID/RSP_READY    response handshake
//   RSP_DATA/RSP_ERR       result (held while waiting), reserved-op flag
//   BUSY                   high whenever not IDLE
module shift_sequencer
    import mic1_shift_pkg::*;
#(
    parameter int CNT_W      = 5,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [DATA_W-1:0] REQ_DATA,
    input  logic [CNT_W-1:0]  REQ_CNT,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ERR,
    output logic              BUSY
);

    seq_state_t        r_state;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    shift_op_t         r_op;
    logic              r_err;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic              r_busy;

    shift_op_t         w_set;
    shift_op_t         w_req_op;
    logic [DATA_W-1:0] w_shift;
    logic              w_exit;

    // Shifter sees a real op only while running; RSVD never reaches RUN.
    assign w_set    = (r_state == RUN) ? r_op : SH_PASS;
    assign w_req_op = shift_op_t'(REQ_OP);

    shift_sequencer_shifter u_shifter (
        .i_alu_out (r_acc),
        .i_set     (w_set),
        .o_shift   (w_shift)
    );

    // Fixed points: SLL8 sticks at 0, SRA1 sticks at 0 or all-ones.
    assign w_exit = EARLY_EXIT &&
                    (((r_op == SH_SLL8) && (w_shift == '0)) ||
                     ((r_op == SH_SRA1) && ((w_shift == '0) || (w_shift == '1))));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_op        <= SH_PASS;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (REQ_VALID) begin
                        r_acc       <= REQ_DATA;
                        r_op        <= w_req_op;
                        r_cnt       <= REQ_CNT;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_req_op == SH_RSVD) begin
                            r_acc       <= '0;
                            r_err       <= 1'b1;
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_err   <= 1'b1;
                        end else if ((w_req_op == SH_PASS) || (REQ_CNT == '0)) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= REQ_DATA;
                            r_rsp_err   <= 1'b0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_acc <= w_shift;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if ((r_cnt == CNT_W'(1)) || w_exit) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_shift;
                        r_rsp_err   <= r_err;
                    end
                end
                DONE: begin
                    if (RSP_READY) begin
                        r_state     <= IDLE;
                        r_err       <= 1'b0;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_READY = r_req_ready;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ERR   = r_rsp_err;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Scoreboard bench: dut_a has early exit enabled, dut_b runs every pass.
//   The driver pushes the expected response on accept; per-DUT monitors pop
//   and compare data, error flag and accept-to-valid latency.
module tb_shift_sequencer;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [4:0]  req_cnt;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err, a_busy;
    logic [31:0] a_rsp_data;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err, b_busy;
    logic [31:0] b_rsp_data;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    bit   sa = 0, sb = 0;
    int   la, lb;
    logic [31:0] ha, hb;

    shift_sequencer #(.CNT_W(5), .EARLY_EXIT(1'b1)) dut_a (
        .CLK(clk), .RST(rst),
        .REQ_VALID(a_req_valid), .REQ_READY(a_req_ready),
        .REQ_OP(req_op), .REQ_DATA(req_data), .REQ_CNT(req_cnt),
        .RSP_VALID(a_rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(a_rsp_data), .RSP_ERR(a_rsp_err), .BUSY(a_busy)
    );

    shift_sequencer #(.CNT_W(5), .EARLY_EXIT(1'b0)) dut_b (
        .CLK(clk), .RST(rst),
        .REQ_VALID(b_req_valid), .REQ_READY(b_req_ready),
        .REQ_OP(req_op), .REQ_DATA(req_data), .REQ_CNT(req_cnt),
        .RSP_VALID(b_rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(b_rsp_data), .RSP_ERR(b_rsp_err), .BUSY(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic send(input bit b, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] n, input logic [31:0] ed, input logic ee,
                        input int el);
        int   i;
        exp_t e;
        i = 0;
        while (!(b ? b_req_ready : a_req_ready) && i < 200) begin
            @(posedge clk); #1;
            i++;
        end
        if (i >= 200) begin
            fail("req_ready_timeout");
            return;
        end
        req_op = op; req_data = d; req_cnt = n;
        if (b) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        e.data = ed; e.err = ee; e.lat = el; e.acc = cyc;
        if (b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((qa.size() != 0 || qb.size() != 0) && i < 100) begin
            @(posedge clk); #1;
            i++;
        end
        if (i >= 100) begin
            fail("response_timeout");
            qa.delete();
            qb.delete();
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && a_rsp_valid) begin
            if (!sa) begin
                sa = 1;
                ha = a_rsp_data;
                if (qa.size() == 0) fail("a_unexpected_rsp");
                else la = cyc - qa[0].acc;
            end else begin
                chk("a_rsp_hold", a_rsp_data, ha);
            end
            if (rsp_ready && qa.size() != 0) begin
                ea = qa.pop_front();
                chk("a_rsp_data", a_rsp_data, ea.data);
                chk("a_rsp_err", {31'd0, a_rsp_err}, {31'd0, ea.err});
                chk("a_latency", 32'(la), 32'(ea.lat));
            end
            if (rsp_ready) sa = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && b_rsp_valid) begin
            if (!sb) begin
                sb = 1;
                hb = b_rsp_data;
                if (qb.size() == 0) fail("b_unexpected_rsp");
                else lb = cyc - qb[0].acc;
            end else begin
                chk("b_rsp_hold", b_rsp_data, hb);
            end
            if (rsp_ready && qb.size() != 0) begin
                eb = qb.pop_front();
                chk("b_rsp_data", b_rsp_data, eb.data);
                chk("b_rsp_err", {31'd0, b_rsp_err}, {31'd0, eb.err});
                chk("b_latency", 32'(lb), 32'(eb.lat));
            end
            if (rsp_ready) sb = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        req_op = 2'b00; req_data = '0; req_cnt = '0;
        rsp_ready = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_data", a_rsp_data, 32'd0);
        chk("rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_b_req_ready", {31'd0, b_req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: one SLL8 pass
        send(0, 2'b01, 32'hAAAAAAAA, 5'd1, 32'hAAAAAA00, 1'b0, 1);
        drain();

        // 2: SRA1, four passes and one pass
        send(0, 2'b10, 32'hAAAAAAAA, 5'd4, 32'hFAAAAAAA, 1'b0, 4);
        chk("set_run_sra1", 32'(dut_a.w_set), 32'd2);
        chk("busy_run", {31'd0, a_busy}, 32'd1);
        drain();
        send(0, 2'b10, 32'hAAAAAAAA, 5'd1, 32'hD5555555, 1'b0, 1);
        drain();

        // 3: pass op, reserved op, zero count
        send(0, 2'b00, 32'hAAAAAAAA, 5'd7, 32'hAAAAAAAA, 1'b0, 0);
        chk("set_pass", 32'(dut_a.w_set), 32'd0);
        drain();
        send(0, 2'b11, 32'hAAAAAAAA, 5'd5, 32'h00000000, 1'b1, 0);
        chk("set_rsvd", 32'(dut_a.w_set), 32'd0);
        drain();
        send(0, 2'b01, 32'h12345678, 5'd0, 32'h12345678, 1'b0, 0);
        drain();

        // 4: early exit versus full count
        send(0, 2'b01, 32'h12345678, 5'd31, 32'h00000000, 1'b0, 4);
        drain();
        send(1, 2'b01, 32'h12345678, 5'd31, 32'h00000000, 1'b0, 31);
        drain();
        send(0, 2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 31);
        drain();
        send(0, 2'b10, 32'h00000100, 5'd31, 32'h00000000, 1'b0, 9);
        drain();
        send(1, 2'b10, 32'h00000100, 5'd31, 32'h00000000, 1'b0, 31);
        drain();

        // 5: consumer stalls in DONE while a new request is offered
        rsp_ready = 1'b0;
        send(0, 2'b01, 32'h000000FF, 5'd2, 32'h00FF0000, 1'b0, 2);
        for (int i = 0; i < 50 && !a_rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("stall_rsp_valid", {31'd0, a_rsp_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            req_op = 2'b10; req_data = 32'hDEADBEEF; req_cnt = 5'd3;
            a_req_valid = 1'b1;
            chk("stall_req_ready", {31'd0, a_req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        a_req_valid = 1'b0;
        chk("stall_still_valid", {31'd0, a_rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        drain();

        // 6: asynchronous reset during pass 3 of a 20-pass run
        send(0, 2'b10, 32'h80000000, 5'd20, 32'hFFFFFFFF, 1'b0, 20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, a_busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_req_ready", {31'd0, a_req_ready}, 32'd1);
        chk("mid_rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("mid_rst_rsp_data", a_rsp_data, 32'd0);
        chk("mid_rst_rsp_err", {31'd0, a_rsp_err}, 32'd0);
        chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        qa.delete();
        sa = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_no_rsp", {31'd0, a_rsp_valid}, 32'd0);
        send(0, 2'b01, 32'h00000001, 5'd3, 32'h01000000, 1'b0, 3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
